gate_unit_pipe: RTL and testbench

- Parametrised, registered successor to the single 2-input OR gate: a WIDTH-bit, two-operand bitwise logic unit.
- Operation (AND/OR/XOR/NAND/NOR/XNOR/NOT/PASS) is selected per transaction.
- Valid/ready handshakes on input and output; output side is buffered so back-pressure never drops or duplicates data.
- Sits between stimulus/register logic and downstream consumers in the logic_gates library; also serves as the common gate primitive for later multi-gate benches.

---
 rtl/gate_pkg.sv | 39 +++
 rtl/gate_unit_pipe_if.sv | 29 ++
 rtl/gate_skid_buf.sv | 73 +++++++
 rtl/gate_unit_pipe.sv | 49 ++++
 tb/tb_gate_unit_pipe.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/gate_pkg.sv
// Shared opcode enum and width-generic bitwise gate function for the gate unit.
package gate_pkg;

  localparam int unsigned GATE_OP_W  = 3;
  // Widest operand gate_apply handles; callers zero-extend in and truncate out.
  localparam int unsigned GATE_MAX_W = 256;

  typedef enum logic [GATE_OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NAND  = 3'd3,
    OP_NOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOT_A = 3'd6,
    OP_PASS  = 3'd7
  } gate_op_e;

  // Bits are independent, so upper bits filled by extension never reach a truncated result.
  function automatic logic [GATE_MAX_W-1:0] gate_apply(
    input gate_op_e                op,
    input logic [GATE_MAX_W-1:0]   a,
    input logic [GATE_MAX_W-1:0]   b
  );
    logic [GATE_MAX_W-1:0] y;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_NOT_A: y = ~a;
      default:  y = a;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_unit_pipe_if.sv
// Handshake bus of the gate unit: input transaction, buffered result and counter.
interface gate_unit_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  import gate_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  gate_op_e         in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_any;
  logic             out_all;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_any, out_all, done_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_y, out_any, out_all, done_cnt
  );
endinterface

// File: rtl/gate_skid_buf.sv
// Two-entry result buffer: main register R feeds the output, skid entry S absorbs one stall.
module gate_skid_buf #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  logic          r_valid_q, r_valid_d;
  logic [DW-1:0] r_data_q,  r_data_d;
  logic          s_valid_q, s_valid_d;
  logic [DW-1:0] s_data_q,  s_data_d;
  logic          in_ready_q, in_ready_d;
  logic          in_hs, out_hs;

  // S is only ever occupied while R is full, so R-empty never needs to look at S.
  always_comb begin
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    in_hs     = in_valid_i & in_ready_q;
    out_hs    = r_valid_q & out_ready_i;

    if (!r_valid_q) begin
      if (in_hs) begin
        r_valid_d = 1'b1;
        r_data_d  = in_data_i;
      end
    end else if (out_hs) begin
      if (s_valid_q) begin
        r_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (in_hs) begin
        r_data_d  = in_data_i;
      end else begin
        r_valid_d = 1'b0;
      end
    end else if (in_hs) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data_i;
    end

    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      s_valid_q  <= 1'b0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      s_valid_q  <= s_valid_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = r_valid_q;
  assign out_data_o  = r_data_q;

endmodule

// File: rtl/gate_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit with valid/ready on both sides and a handshake counter.
module gate_unit_pipe
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  gate_unit_pipe_if.slave bus
);

  logic [WIDTH-1:0] y_c;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  assign y_c = WIDTH'(gate_apply(bus.in_op, GATE_MAX_W'(bus.in_a), GATE_MAX_W'(bus.in_b)));

  gate_skid_buf #(
    .DW (WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (y_c),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (bus.out_y)
  );

  // Reductions are masked so an idle output never advertises stale data.
  assign bus.out_any = bus.out_valid & (|bus.out_y);
  assign bus.out_all = bus.out_valid & (&bus.out_y);

  always_comb begin
    done_cnt_d = done_cnt_q + CNT_W'(bus.out_valid & bus.out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt_q <= '0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign bus.done_cnt = done_cnt_q;

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Self-checking bench for gate_unit_pipe: vector tables, corner sequences and a queue model.
module tb_gate_unit_pipe;
  import gate_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic [7:0]  mq[$];
  logic [15:0] m_cnt;

  gate_unit_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();
  gate_unit_pipe_if #(.WIDTH(8), .CNT_W(4))  w4 ();

  gate_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  gate_unit_pipe #(.WIDTH(8), .CNT_W(4))  dut_w4 (.clk(clk), .rst(rst), .bus(w4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } op_vec_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       any;
    logic       all;
  } red_vec_t;

  function automatic logic [7:0] gold(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the in-flight queue of the model.
  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (mq.size() > 0) ? mq[0] : 8'h00;
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'(mq.size() < 2));
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, "_out_y"}, 32'(bus.out_y), 32'(head));
    chk({tag, "_out_any"},  32'(bus.out_any),  32'((mq.size() > 0) && (head != 8'h00)));
    chk({tag, "_out_all"},  32'(bus.out_all),  32'((mq.size() > 0) && (head == 8'hFF)));
    chk({tag, "_done_cnt"}, 32'(bus.done_cnt), 32'(m_cnt));
  endtask

  // Called at a falling edge; applies one cycle of stimulus and advances the model.
  task automatic step(input string tag, input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic ordy);
    logic acc, pop;
    check_state(tag);
    bus.in_valid  = v;
    bus.in_a      = v ? a : 8'hxx;
    bus.in_b      = v ? b : 8'hxx;
    bus.in_op     = gate_op_e'(v ? op : 3'($urandom_range(0, 7)));
    bus.out_ready = ordy;
    acc = v && (mq.size() < 2);
    pop = ordy && (mq.size() > 0);
    @(posedge clk);
    if (pop) begin
      void'(mq.pop_front());
      m_cnt++;
    end
    if (acc) mq.push_back(gold(op, a, b));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'hA5;
    bus.in_b     = 8'h5A;
    bus.in_op    = OP_OR;
    repeat (2) @(posedge clk);
    mq.delete();
    m_cnt = '0;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  op_vec_t  t1[8];
  red_vec_t t4[3];

  initial begin
    logic [15:0] cnt0;
    n_chk  = 0;
    n_fail = 0;
    m_cnt  = '0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = OP_AND; bus.out_ready = 1'b0;
    w4.in_valid  = 1'b0; w4.in_a  = '0; w4.in_b  = '0; w4.in_op  = OP_AND; w4.out_ready  = 1'b0;

    t1[0] = '{3'd0, 8'hF0, 8'hCC, 8'hC0};
    t1[1] = '{3'd1, 8'hF0, 8'hCC, 8'hFC};
    t1[2] = '{3'd2, 8'hF0, 8'hCC, 8'h3C};
    t1[3] = '{3'd3, 8'hF0, 8'hCC, 8'h3F};
    t1[4] = '{3'd4, 8'hF0, 8'hCC, 8'h03};
    t1[5] = '{3'd5, 8'hF0, 8'hCC, 8'hC3};
    t1[6] = '{3'd6, 8'hF0, 8'hCC, 8'h0F};
    t1[7] = '{3'd7, 8'hF0, 8'hCC, 8'hF0};
    t4[0] = '{3'd0, 8'hFF, 8'hFF, 1'b1, 1'b1};
    t4[1] = '{3'd0, 8'h00, 8'hFF, 1'b0, 1'b0};
    t4[2] = '{3'd4, 8'h00, 8'h00, 1'b1, 1'b1};

    @(negedge clk);
    do_reset();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_y",     32'(bus.out_y),     32'd0);
    chk("rst_out_any",   32'(bus.out_any),   32'd0);
    chk("rst_out_all",   32'(bus.out_all),   32'd0);
    chk("rst_done_cnt",  32'(bus.done_cnt),  32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // All opcodes, one result per cycle.
    for (int i = 0; i < 8; i++) begin
      step("t1", 1'b1, t1[i].a, t1[i].b, t1[i].op, 1'b1);
      chk($sformatf("t1_valid_op%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("t1_y_op%0d", i), 32'(bus.out_y), 32'(t1[i].y));
    end
    step("t1d", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("t1_done_cnt", 32'(bus.done_cnt), 32'd8);

    // Back-pressure fills R then S.
    step("t2a", 1'b1, 8'h01, 8'h02, 3'd1, 1'b0);
    chk("t2_y_first", 32'(bus.out_y), 32'h03);
    chk("t2_rdy_first", 32'(bus.in_ready), 32'd1);
    step("t2b", 1'b1, 8'hFF, 8'h0F, 3'd2, 1'b0);
    chk("t2_rdy_full", 32'(bus.in_ready), 32'd0);
    chk("t2_y_hold", 32'(bus.out_y), 32'h03);
    step("t2c", 1'b1, 8'h77, 8'h77, 3'd0, 1'b0);
    chk("t2_y_stall", 32'(bus.out_y), 32'h03);
    step("t2d", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("t2_y_second", 32'(bus.out_y), 32'hF0);
    chk("t2_rdy_back", 32'(bus.in_ready), 32'd1);
    step("t2e", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("t2_drained", 32'(bus.out_valid), 32'd0);

    // Streaming at full rate.
    cnt0 = m_cnt;
    for (int i = 0; i < 100; i++) begin
      step("t3", 1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b1);
      chk("t3_rate", 32'(bus.out_valid), 32'd1);
    end
    step("t3d", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    chk("t3_done_cnt", 32'(bus.done_cnt), 32'(cnt0 + 16'd100));

    // Reductions.
    for (int i = 0; i < 3; i++) begin
      step("t4", 1'b1, t4[i].a, t4[i].b, t4[i].op, 1'b0);
      chk($sformatf("t4_any_%0d", i), 32'(bus.out_any), 32'(t4[i].any));
      chk($sformatf("t4_all_%0d", i), 32'(bus.out_all), 32'(t4[i].all));
      step("t4d", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    end

    // Random valid/ready traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    check_state("rnd_end");

    // Reset with R and S both holding results.
    step("t5a", 1'b1, 8'h11, 8'h22, 3'd0, 1'b0);
    step("t5b", 1'b1, 8'h33, 8'h44, 3'd1, 1'b0);
    chk("t5_full", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    do_reset();
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_in_ready",  32'(bus.in_ready),  32'd1);
    chk("t5_done_cnt",  32'(bus.done_cnt),  32'd0);
    for (int i = 0; i < 3; i++) begin
      step("t5s", 1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      chk("t5_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // 4-bit counter wrap on the second instance.
    for (int i = 1; i <= 17; i++) begin
      w4.in_valid = 1'b1; w4.in_a = 8'(i); w4.in_b = 8'h00; w4.in_op = OP_OR; w4.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      w4.in_valid = 1'b0; w4.out_ready = 1'b1;
      chk($sformatf("t6_y_%0d", i), 32'(w4.out_y), 32'(i));
      @(posedge clk);
      @(negedge clk);
      w4.out_ready = 1'b0;
      chk($sformatf("t6_cnt_%0d", i), 32'(w4.done_cnt), 32'(i % 16));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
